// File: rtl/analog_test_seq_pkg.sv
// rtl/analog_test_seq_pkg.sv - shared types and sizing for the analog test sequencer
//
// Purpose: state enum, default geometry and the config-word width helper
// used by analog_test_seq and analog_test_seq_next.
// Ports: none (package).

package analog_test_seq_pkg;

  localparam int DEF_NUM_CELLS = 8;
  localparam int DEF_SETTLE_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    SETTLE = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  // Config word is {settle, mask}.
  function automatic int cfg_w(input int settle_w, input int num_cells);
    return settle_w + num_cells;
  endfunction

  localparam int CFG_W = cfg_w(DEF_SETTLE_W, DEF_NUM_CELLS);

endpackage

// File: rtl/analog_test_seq_next.sv
// rtl/analog_test_seq_next.sv - finds the next set mask bit above an index
//
// Purpose: combinational search over the cell mask.
// Ports:
//   mask       in  NUM_CELLS  cell enable mask
//   idx        in  3          search strictly above this index
//   from_start in  1          ignore idx and return the lowest set bit
//   next_idx   out 3          index found (0 when none)
//   found      out 1          a qualifying bit exists

module analog_test_seq_next
  import analog_test_seq_pkg::*;
#(
  parameter int NUM_CELLS = DEF_NUM_CELLS
) (
  input  logic [NUM_CELLS-1:0] mask,
  input  logic [2:0]           idx,
  input  logic                 from_start,
  output logic [2:0]           next_idx,
  output logic                 found
);

  // Scan downward so the last hit, which wins, is the lowest qualifying bit.
  always_comb begin
    found    = 1'b0;
    next_idx = 3'd0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(idx)))) begin
        found    = 1'b1;
        next_idx = i[2:0];
      end
    end
  end

endmodule

// File: rtl/analog_test_seq.sv
// rtl/analog_test_seq.sv - break-before-make sequencer for on-die analog test cells
//
// Purpose: connects one test cell at a time to the analog pad path, with a
// one-cycle open gap between cells and a programmable settle time, then
// requests a capture and waits for the acknowledge.
// Build option: ANALOG_TEST_SEQ_LOOP_EN - wrap back to the lowest enabled cell
// after the last one (re-latching config) instead of returning to IDLE.
// Ports:
//   clk, rst          tile clock, asynchronous active-high reset
//   cfg_shift/data    serial config load {settle, mask}, MSB first, idle only
//   start, stop       level start (IDLE only), level abort (highest priority)
//   sample_ack        capture logic has taken the sample
//   cell_en           one-hot switch enables (registered)
//   cell_idx          current or last connected cell
//   sample_req, busy, done   capture request, non-IDLE flag, end-of-pass pulse

module analog_test_seq
  import analog_test_seq_pkg::*;
#(
  parameter int NUM_CELLS = DEF_NUM_CELLS,
  parameter int SETTLE_W  = DEF_SETTLE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_shift,
  input  logic                 cfg_data,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 sample_ack,
  output logic [NUM_CELLS-1:0] cell_en,
  output logic [2:0]           cell_idx,
  output logic                 sample_req,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = cfg_w(SETTLE_W, NUM_CELLS);

  state_t               state_q, state_d;
  logic [CW-1:0]        shift_q;
  logic [CW-1:0]        act_q, act_d;
  logic [2:0]           tgt_q, tgt_d;
  logic [SETTLE_W-1:0]  cnt_q, cnt_d;

  logic [NUM_CELLS-1:0] cell_en_d;
  logic [2:0]           cell_idx_d;
  logic                 sample_req_d, busy_d, done_d;

  logic [NUM_CELLS-1:0] act_mask;
  logic [SETTLE_W-1:0]  act_settle;
  logic [2:0]           first_idx, after_idx;
  logic                 first_found, after_found;

  assign act_mask   = act_q[NUM_CELLS-1:0];
  assign act_settle = act_q[CW-1:NUM_CELLS];

  // Lowest cell of the config about to be latched (start, or loop wrap).
  analog_test_seq_next #(.NUM_CELLS(NUM_CELLS)) u_first (
    .mask       (shift_q[NUM_CELLS-1:0]),
    .idx        (3'd0),
    .from_start (1'b1),
    .next_idx   (first_idx),
    .found      (first_found)
  );

  // Next cell above the current target within the running config.
  analog_test_seq_next #(.NUM_CELLS(NUM_CELLS)) u_after (
    .mask       (act_mask),
    .idx        (tgt_q),
    .from_start (1'b0),
    .next_idx   (after_idx),
    .found      (after_found)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            act_d = shift_q;
            if (first_found) begin
              state_d = GAP;
              tgt_d   = first_idx;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        GAP: begin
          state_d = SETTLE;
          cnt_d   = act_settle;
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q - SETTLE_W'(1);
          end
        end
        SAMPLE: begin
          // sample_req is always high in SAMPLE, so ack alone completes it.
          if (sample_ack) begin
            if (after_found) begin
              state_d = GAP;
              tgt_d   = after_idx;
            end else begin
              done_d = 1'b1;
`ifdef ANALOG_TEST_SEQ_LOOP_EN
              act_d = shift_q;
              if (first_found) begin
                state_d = GAP;
                tgt_d   = first_idx;
              end else begin
                state_d = IDLE;
              end
`else
              state_d = IDLE;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered copies of what the next state implies.
    busy_d       = (state_d != IDLE);
    sample_req_d = (state_d == SAMPLE);
    cell_en_d    = '0;
    cell_idx_d   = cell_idx;
    if (state_d == SETTLE || state_d == SAMPLE) begin
      cell_en_d = NUM_CELLS'(1) << tgt_d;
    end
    if (state_d == SETTLE) begin
      cell_idx_d = tgt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      act_q      <= '0;
      tgt_q      <= 3'd0;
      cnt_q      <= '0;
      cell_en    <= '0;
      cell_idx   <= 3'd0;
      sample_req <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      cell_en    <= cell_en_d;
      cell_idx   <= cell_idx_d;
      sample_req <= sample_req_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Config loads only while idle so a running pass never sees a partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (cfg_shift && !busy) begin
      shift_q <= {shift_q[CW-2:0], cfg_data};
    end
  end

endmodule

// File: tb/tb_analog_test_seq.sv
// tb/tb_analog_test_seq.sv - self-checking bench for analog_test_seq

module tb_analog_test_seq;

  localparam int NC = 8;
  localparam int SW = 8;
  localparam int CW = SW + NC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_shift = 1'b0, cfg_data = 1'b0;
  logic          start = 1'b0, stop = 1'b0, sample_ack = 1'b0;
  logic [NC-1:0] cell_en;
  logic [2:0]    cell_idx;
  logic          sample_req, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  analog_test_seq #(.NUM_CELLS(NC), .SETTLE_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_shift  (cfg_shift),
    .cfg_data   (cfg_data),
    .start      (start),
    .stop       (stop),
    .sample_ack (sample_ack),
    .cell_en    (cell_en),
    .cell_idx   (cell_idx),
    .sample_req (sample_req),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [NC-1:0] en;
    logic          req;
    logic          busy;
    logic          done;
    logic [2:0]    idx;
  } obs_t;

  typedef struct {
    logic [NC-1:0] mask;
    logic [SW-1:0] settle;
    int            wait0;
    int            d_lat;
    int            en_cnt;
  } vec_t;

  obs_t       exp_q[$];
  logic       ack_q[$];
  logic       samp_q[$];
  logic [2:0] exp_idx;
  int         waits[NC];
  vec_t       vt[7];

  logic [NC-1:0] rm, prev_en;
  logic [SW-1:0] rs;
  int            dl, ec, t, nd, ndb;
  int            seq[$];

  function automatic obs_t mk(input logic [NC-1:0] en, input logic req, input logic b,
                              input logic d, input logic [2:0] idx);
    obs_t o;
    o.en = en; o.req = req; o.busy = b; o.done = d; o.idx = idx;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t e);
    obs_t a;
    a = mk(cell_en, sample_req, busy, done, cell_idx);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got en=%h req=%b busy=%b done=%b idx=%0d, expected en=%h req=%b busy=%b done=%b idx=%0d",
                  name, a.en, a.req, a.busy, a.done, a.idx, e.en, e.req, e.busy, e.done, e.idx);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  task automatic shift_cfg(input logic [CW-1:0] w);
    for (int i = CW - 1; i >= 0; i--) begin
      cfg_shift = 1'b1;
      cfg_data  = w[i];
      @(negedge clk);
    end
    cfg_shift = 1'b0;
    cfg_data  = 1'b0;
  endtask

  task automatic clear_waits();
    for (int i = 0; i < NC; i++) waits[i] = 0;
  endtask

  // Expected per-cycle trace from the cycle after start: for each enabled cell
  // in ascending order, one open gap, settle+1 connected cycles, then wait+1
  // requesting cycles (ack on the last); then a done cycle and one idle cycle.
  task automatic build(input logic [NC-1:0] mask, input logic [SW-1:0] settle, input int stop_at);
    logic [NC-1:0] oh;
    logic [2:0]    idx0;
    exp_q.delete(); ack_q.delete(); samp_q.delete();
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) begin
        oh = '0; oh[c] = 1'b1;
        exp_q.push_back(mk('0, 1'b0, 1'b1, 1'b0, exp_idx)); ack_q.push_back(1'b0); samp_q.push_back(1'b0);
        exp_idx = 3'(c);
        for (int s = 0; s <= int'(settle); s++) begin
          exp_q.push_back(mk(oh, 1'b0, 1'b1, 1'b0, exp_idx)); ack_q.push_back(1'b0); samp_q.push_back(1'b0);
        end
        for (int w = 0; w <= waits[c]; w++) begin
          exp_q.push_back(mk(oh, 1'b1, 1'b1, 1'b0, exp_idx)); ack_q.push_back(w == waits[c]); samp_q.push_back(1'b1);
        end
      end
    end
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, exp_idx)); ack_q.push_back(1'b0); samp_q.push_back(1'b0);
    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, exp_idx)); ack_q.push_back(1'b0); samp_q.push_back(1'b0);
    if (stop_at >= 0) begin
      idx0 = exp_q[stop_at].idx;
      while (exp_q.size() > stop_at + 1) begin
        void'(exp_q.pop_back()); void'(ack_q.pop_back()); void'(samp_q.pop_back());
      end
      for (int i = 0; i < 2; i++) begin
        exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, idx0)); ack_q.push_back(1'b0); samp_q.push_back(1'b0);
      end
      exp_idx = idx0;
    end
  endtask

  task automatic run_pass(input logic [NC-1:0] mask, input logic [SW-1:0] settle, input int stop_at,
                          input bit do_shift, input bit noise, output int d_lat, output int en_cnt);
    if (do_shift) shift_cfg({settle, mask});
    build(mask, settle, stop_at);
    d_lat  = -1;
    en_cnt = 0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check_obs($sformatf("trace m=%h s=%0d k=%0d", mask, settle, k), exp_q[k]);
      if (cell_en != '0) en_cnt++;
      if (done && d_lat < 0) d_lat = k + 1;
      stop = (k == stop_at);
      if (ack_q[k]) sample_ack = 1'b1;
      else if (noise && !samp_q[k]) sample_ack = 1'($urandom_range(0, 1));
      else sample_ack = 1'b0;
      if (noise && exp_q[k].busy) begin
        cfg_shift = 1'($urandom_range(0, 1));
        cfg_data  = 1'($urandom_range(0, 1));
      end else begin
        cfg_shift = 1'b0;
      end
      @(negedge clk);
    end
    stop = 1'b0; sample_ack = 1'b0; cfg_shift = 1'b0; cfg_data = 1'b0;
  endtask

  initial begin
    // Table: mask, settle, ack delay on cell 0, start-to-done cycles, cycles with a cell connected.
    vt[0] = '{8'h05, 8'd2,   0, 11,  8};
    vt[1] = '{8'h00, 8'd5,   0,  1,  0};
    vt[2] = '{8'h05, 8'd2,   5, 16, 13};
    vt[3] = '{8'h80, 8'd0,   0,  4,  2};
    vt[4] = '{8'hFF, 8'd1,   0, 33, 24};
    vt[5] = '{8'h12, 8'd255, 0, 517, 514};
    vt[6] = '{8'h41, 8'd3,   2, 15, 12};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_obs("reset_held", obs_t'(0));
    rst = 1'b0;
    @(negedge clk);
    check_obs("reset_released", obs_t'(0));
    exp_idx = 3'd0;

`ifdef ANALOG_TEST_SEQ_LOOP_EN
    shift_cfg({8'd0, 8'h81});
    sample_ack = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; ndb = 0; prev_en = '0; seq.delete();
    for (int k = 0; k < 20; k++) begin
      if (cell_en != '0 && prev_en == '0) seq.push_back(int'(cell_idx));
      if (done) nd++;
      if (done && busy) ndb++;
      prev_en = cell_en;
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++)
      check_int($sformatf("loop_order_%0d", i), (seq.size() > i) ? seq[i] : -1, (i % 2) ? 7 : 0);
    check_int("loop_done_count", nd, 3);
    check_int("loop_done_at_wrap", ndb, 3);
    stop = 1'b1; sample_ack = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    check_obs("loop_stop", mk('0, 1'b0, 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    check_obs("loop_stop_no_done", mk('0, 1'b0, 1'b0, 1'b0, 3'd0));
    exp_idx = 3'd0;
`else
    for (int v = 0; v < 7; v++) begin
      clear_waits();
      waits[0] = vt[v].wait0;
      run_pass(vt[v].mask, vt[v].settle, -1, 1'b1, 1'b0, dl, ec);
      check_int($sformatf("vec%0d_done_latency", v), dl, vt[v].d_lat);
      check_int($sformatf("vec%0d_connected_cycles", v), ec, vt[v].en_cnt);
    end

    // stop during SETTLE of cell 2, then stop coinciding with the first ack
    clear_waits();
    run_pass(8'h05, 8'd3, 8, 1'b1, 1'b0, dl, ec);
    check_int("stop_settle_no_done", dl, -1);
    waits[0] = 2;
    run_pass(8'h05, 8'd1, 5, 1'b1, 1'b0, dl, ec);
    check_int("stop_ack_no_done", dl, -1);

    // cfg_shift noise while busy must not disturb this pass or the stored config
    clear_waits();
    run_pass(8'h0A, 8'd2, -1, 1'b1, 1'b1, dl, ec);
    check_int("shift_busy_latency", dl, 11);
    run_pass(8'h0A, 8'd2, -1, 1'b0, 1'b0, dl, ec);
    check_int("shift_busy_cfg_kept", dl, 11);
    run_pass(8'h30, 8'd1, -1, 1'b1, 1'b0, dl, ec);
    check_int("new_cfg_used", dl, 9);

    for (int r = 0; r < 20; r++) begin
      rm = (r % 5 == 0) ? '0 : NC'($urandom_range(1, 255));
      rs = SW'($urandom_range(0, 6));
      for (int i = 0; i < NC; i++) waits[i] = $urandom_range(0, 4);
      run_pass(rm, rs, -1, 1'b1, 1'b1, dl, ec);
    end
`endif

    // Asynchronous reset while waiting in SAMPLE
    clear_waits();
    shift_cfg({8'd0, 8'h01});
    sample_ack = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!sample_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_int("reached_sample", int'(sample_req), 1);
    #2 rst = 1'b1;
    #1 check_obs("async_reset", obs_t'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_idx = 3'd0;
    @(negedge clk);
    run_pass(8'h00, 8'd0, -1, 1'b0, 1'b0, dl, ec);
    check_int("reset_cleared_cfg", dl, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/analog_test_seq.md
# analog_test_seq

Sequencer that shares the tile's analog pad path between up to eight on-die test cells. It connects one cell at a time with a break-before-make gap, waits a programmable settle time, and then hands a sample request to the external capture logic. Configuration is shifted in serially from the dedicated inputs. It sits between the tile top-level I/O decode and the analog switch enables.

## Interface
Parameters:
- NUM_CELLS, default 8: number of test cells (2..8). Also the width of the cell mask.
- SETTLE_W, default 8: width of the settle counter.

Ports:
- clk  in  1: tile clock.
- rst  in  1: asynchronous, active-high reset.
- cfg_shift  in  1: shift-enable for the configuration register.
- cfg_data  in  1: serial configuration bit, MSB first.
- start  in  1: level; begins a pass when sampled high in IDLE.
- stop  in  1: level; aborts any activity.
- sample_ack  in  1: capture logic has taken the sample.
- cell_en  out  NUM_CELLS: one-hot analog switch enables. All zero when no cell is connected.
- cell_idx  out  3: index of the current or last connected cell.
- sample_req  out  1: request to capture the current cell.
- busy  out  1: high in any state other than IDLE.
- done  out  1: one-cycle pulse at the end of a pass.

## Operation
- Config shift register width is SETTLE_W+NUM_CELLS, laid out as {settle, mask}.
  - When cfg_shift=1 and busy=0, the register shifts left by one each cycle with cfg_data entering at the LSB.
  - cfg_shift is ignored while busy=1.
- The active config is copied from the shift register on the cycle start is accepted, so a shift during a pass has no effect on that pass.
- States:
  - IDLE: cell_en=0, sample_req=0.
    - start=1 with mask≠0: go to GAP, targeting the lowest set mask bit.
    - start=1 with mask=0: done pulses next cycle and the state stays IDLE.
  - GAP: exactly one cycle with cell_en=0. Then go to SETTLE.
  - SETTLE: cell_en = one-hot of the target cell and cell_idx = target. The counter loads settle and decrements each cycle.
    - Exit to SAMPLE on the cycle the count is zero.
    - settle=0 gives one SETTLE cycle.
  - SAMPLE: cell_en held, sample_req=1.
    - On a cycle with sample_req & sample_ack, sample_req drops on the next cycle.
    - If a higher mask bit is set, go to GAP targeting the next higher set bit.
    - Otherwise go to IDLE and pulse done.
- stop=1 in any state: next cycle is IDLE with cell_en=0 and sample_req=0, and no done pulse. stop takes priority over start and sample_ack in the same cycle.
- There is no ack timeout; SAMPLE waits indefinitely.
- sample_ack outside SAMPLE is ignored.

## Timing
- Reset values: cell_en=0, cell_idx=0, sample_req=0, busy=0, done=0, shift register=0, active config=0, state=IDLE.
- All outputs are registered.
- Start sampled at cycle T:
  - T+1: GAP, busy=1.
  - T+2 .. T+2+settle: cell_en on.
  - T+3+settle: sample_req=1.
- Per-cell cost is 3+settle+ack_wait cycles, where ack_wait=0 when ack is tied high.
- done is asserted in the cycle after the final ack; busy=0 in that same cycle.
- A start held high after a pass begins a new pass from IDLE on the following cycle.
- Reset mid-pass forces all switches open immediately, because the reset is asynchronous.

## Configuration
- ANALOG_TEST_SEQ_LOOP_EN defined: after the last enabled cell, go to GAP targeting the lowest set bit instead of IDLE.
  - done still pulses once per completed pass, coincident with the wrap.
  - The sequencer runs until stop.
  - The active config is re-latched from the shift register at each wrap; if the new mask=0, go to IDLE.
- ANALOG_TEST_SEQ_LOOP_EN undefined: single-pass behaviour as described in Operation.

## Structure
- Package analog_test_seq_pkg holds:
  - the state enum (IDLE, GAP, SETTLE, SAMPLE);
  - CFG_W function/localparam;
  - the default NUM_CELLS and SETTLE_W.
- Sub-module analog_test_seq_next: combinational finder that returns the next set mask bit strictly above a given index, plus a found flag.
  - It is also used with index -1 (encoded as a separate "from_start" input) to get the lowest set bit.

## Test plan
- Mask 8'b0000_0101, settle 2, ack tied high, pulse start → cell_en=0x01 for 3 cycles, sample_req, a 1-cycle gap, cell_en=0x04 for 3 cycles, sample_req, then done at the expected cycle. cell_en is never non-zero in a GAP cycle.
- Mask 0 with start → done after 1 cycle, busy never high, cell_en stays 0.
- Ack delayed 5 cycles on the first cell → sample_req and cell_en are held for 5 extra cycles, and the next cell is unchanged in order.
- stop asserted during SETTLE of cell 2 and, separately, in the same cycle as sample_ack → IDLE next cycle with outputs 0 and no done pulse.
- cfg_shift toggled while busy → the running pass is unaffected and the shift register is unchanged.
  - A new config shifted after done is used by the next start.
- With ANALOG_TEST_SEQ_LOOP_EN, mask 0x81, settle 0 → order is 0, 7, 0, 7… with done once per pass.
  - Asynchronous rst mid-SAMPLE clears all outputs without waiting for a clock edge.
